// File: rtl/gumnut_data_responder.sv
// Data-memory responder for the Gumnut core: single-beat read/write cycles with
// programmable wait states and a registered one-cycle acknowledge.
module gumnut_data_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ClkEn_i,
    input  logic              cyc_i,
    input  logic              stb_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] adr_i,
    input  logic [DATA_W-1:0] dat_i,
    output logic [DATA_W-1:0] dat_o,
    output logic              ack_o,
    output logic              busy_o
);

    localparam int         IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [3:0]        cnt_q;
    logic [3:0]        cnt_d;
    logic              take_req;
    logic              fire;

    logic [ADDR_W-1:0] adr_p0;
    logic              we_p0;
    logic [DATA_W-1:0] wdat_p0;
    logic              hit_p0;
    logic [DATA_W-1:0] rd_word;

    logic              vld_p1;
    logic [DATA_W-1:0] rdat_p1;

    logic [DATA_W-1:0] mem [DEPTH];

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
        return 64'(a) < 64'(DEPTH);
    endfunction

    function automatic logic [IDX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
        return a[IDX_W-1:0];
    endfunction

    assign hit_p0  = addr_in_range(adr_p0);
    assign rd_word = hit_p0 ? mem[addr_index(adr_p0)] : '0;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        take_req = 1'b0;
        fire     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cyc_i && stb_i) begin
                    take_req = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_d = ST_ACK;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WS_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                // Master walking away mid-wait cancels the access outright.
                if (!cyc_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACK: begin
                fire    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Stage p0: request capture; stage p1: acknowledge and read data
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            adr_p0  <= '0;
            we_p0   <= 1'b0;
            wdat_p0 <= '0;
            vld_p1  <= 1'b0;
            rdat_p1 <= '0;
        end else if (ClkEn_i) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vld_p1  <= fire;
            if (take_req) begin
                adr_p0  <= adr_i;
                we_p0   <= we_i;
                wdat_p0 <= dat_i;
            end
            if (fire && !we_p0) begin
                rdat_p1 <= rd_word;
            end
        end
    end

    // Storage survives reset; out-of-range writes are silently dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i && ClkEn_i && fire && we_p0 && hit_p0) begin
            mem[addr_index(adr_p0)] <= wdat_p0;
        end
    end

    assign ack_o  = vld_p1;
    assign dat_o  = rdat_p1;
    assign busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gumnut_data_responder.sv
// Bench for gumnut_data_responder: four instances with different wait-state/depth
// settings share one bus; a per-instance transaction model is compared every cycle.
module tb_gumnut_data_responder;

    localparam int WS [4] = '{1, 0, 3, 2};
    localparam int DP [4] = '{256, 256, 256, 128};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       cyc;
    logic       stb;
    logic       we;
    logic [7:0] adr;
    logic [7:0] wdat;

    logic [7:0] dut_dat  [4];
    logic       dut_ack  [4];
    logic       dut_busy [4];

    int checks   = 0;
    int failures = 0;
    bit mon_on   = 1'b0;

    always #5 clk = ~clk;

    gumnut_data_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_STATES(1)) u_d0 (
        .clk_i(clk), .rst_i(rst_n), .ClkEn_i(en), .cyc_i(cyc), .stb_i(stb), .we_i(we),
        .adr_i(adr), .dat_i(wdat), .dat_o(dut_dat[0]), .ack_o(dut_ack[0]), .busy_o(dut_busy[0]));
    gumnut_data_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_STATES(0)) u_d1 (
        .clk_i(clk), .rst_i(rst_n), .ClkEn_i(en), .cyc_i(cyc), .stb_i(stb), .we_i(we),
        .adr_i(adr), .dat_i(wdat), .dat_o(dut_dat[1]), .ack_o(dut_ack[1]), .busy_o(dut_busy[1]));
    gumnut_data_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_STATES(3)) u_d2 (
        .clk_i(clk), .rst_i(rst_n), .ClkEn_i(en), .cyc_i(cyc), .stb_i(stb), .we_i(we),
        .adr_i(adr), .dat_i(wdat), .dat_o(dut_dat[2]), .ack_o(dut_ack[2]), .busy_o(dut_busy[2]));
    gumnut_data_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(128), .WAIT_STATES(2)) u_d3 (
        .clk_i(clk), .rst_i(rst_n), .ClkEn_i(en), .cyc_i(cyc), .stb_i(stb), .we_i(we),
        .adr_i(adr), .dat_i(wdat), .dat_o(dut_dat[3]), .ack_o(dut_ack[3]), .busy_o(dut_busy[3]));

    // Transaction model: a request is pending from its sample edge; it completes
    // WS+1 enabled edges later, or dies if cyc is low on one of the WS wait edges.
    logic [7:0] m_mem  [4][256];
    bit         m_pend [4];
    int         m_age  [4];
    bit         m_ack  [4];
    logic [7:0] m_dat  [4];
    logic [7:0] m_adr  [4];
    logic [7:0] m_wd   [4];
    bit         m_we   [4];

    task automatic model_step();
        for (int d = 0; d < 4; d++) begin
            bit was_pend;
            was_pend = m_pend[d];
            if (!rst_n) begin
                m_pend[d] = 1'b0;
                m_ack[d]  = 1'b0;
                m_dat[d]  = 8'h00;
            end else if (en) begin
                m_ack[d] = 1'b0;
                if (was_pend) begin
                    m_age[d] = m_age[d] + 1;
                    if (m_age[d] <= WS[d]) begin
                        if (!cyc) m_pend[d] = 1'b0;
                    end else begin
                        m_pend[d] = 1'b0;
                        m_ack[d]  = 1'b1;
                        if (m_we[d]) begin
                            if (int'(m_adr[d]) < DP[d]) m_mem[d][m_adr[d]] = m_wd[d];
                        end else begin
                            m_dat[d] = (int'(m_adr[d]) < DP[d]) ? m_mem[d][m_adr[d]] : 8'h00;
                        end
                    end
                end else if (cyc && stb) begin
                    m_pend[d] = 1'b1;
                    m_age[d]  = 0;
                    m_adr[d]  = adr;
                    m_wd[d]   = wdat;
                    m_we[d]   = we;
                end
            end
        end
    endtask

    task automatic chk(input string nm, input int d, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut=%0d got=%h want=%h t=%0t", nm, d, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial begin
        wait (mon_on);
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 4; d++) begin
                chk("mdl_ack", d, {7'd0, dut_ack[d]}, {7'd0, m_ack[d]});
                chk("mdl_busy", d, {7'd0, dut_busy[d]}, {7'd0, m_pend[d]});
                chk("mdl_dat", d, dut_dat[d], m_dat[d]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input bit w, input logic [7:0] a, input logic [7:0] d);
        cyc  = 1'b1;
        stb  = 1'b1;
        we   = w;
        adr  = a;
        wdat = d;
        step();
        stb = 1'b0;
    endtask

    task automatic finish(input int n);
        repeat (n) step();
        cyc = 1'b0;
        step();
        step();
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        start(1'b1, a, d);
        finish(5);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 8'h00; wdat = 8'h00;
        step();
        step();
        for (int d = 0; d < 4; d++) begin
            chk("rst_ack", d, {7'd0, dut_ack[d]}, 8'h00);
            chk("rst_busy", d, {7'd0, dut_busy[d]}, 8'h00);
            chk("rst_dat", d, dut_dat[d], 8'h00);
        end
        rst_n  = 1'b1;
        mon_on = 1'b1;
        step();

        wr(8'h00, 8'h11);
        wr(8'h01, 8'h22);
        wr(8'h20, 8'h77);
        wr(8'h05, 8'h5A);

        // WS=1 write then read of 0x10
        start(1'b1, 8'h10, 8'hA5);
        chk("t1w_busy_e0", 0, {7'd0, dut_busy[0]}, 8'h01);
        chk("t1w_ack_e0", 0, {7'd0, dut_ack[0]}, 8'h00);
        step();
        chk("t1w_ack_e1", 0, {7'd0, dut_ack[0]}, 8'h00);
        step();
        chk("t1w_ack_e2", 0, {7'd0, dut_ack[0]}, 8'h01);
        chk("t1w_busy_e2", 0, {7'd0, dut_busy[0]}, 8'h00);
        step();
        chk("t1w_ack_e3", 0, {7'd0, dut_ack[0]}, 8'h00);
        finish(2);
        start(1'b0, 8'h10, 8'h00);
        chk("t1r_busy_e0", 0, {7'd0, dut_busy[0]}, 8'h01);
        step();
        chk("t1r_busy_e1", 0, {7'd0, dut_busy[0]}, 8'h01);
        chk("t1r_ack_e1", 0, {7'd0, dut_ack[0]}, 8'h00);
        step();
        chk("t1r_ack_e2", 0, {7'd0, dut_ack[0]}, 8'h01);
        chk("t1r_dat_e2", 0, dut_dat[0], 8'hA5);
        chk("t1r_busy_e2", 0, {7'd0, dut_busy[0]}, 8'h00);
        step();
        chk("t1r_ack_e3", 0, {7'd0, dut_ack[0]}, 8'h00);
        chk("t1r_dat_hold", 0, dut_dat[0], 8'hA5);
        finish(2);

        // WS=0 back-to-back reads with strobe held
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 8'h00;
        step();
        chk("t2_ack_e0", 1, {7'd0, dut_ack[1]}, 8'h00);
        adr = 8'h01;
        step();
        chk("t2_ack_e1", 1, {7'd0, dut_ack[1]}, 8'h01);
        chk("t2_dat_e1", 1, dut_dat[1], 8'h11);
        step();
        chk("t2_ack_e2", 1, {7'd0, dut_ack[1]}, 8'h00);
        step();
        chk("t2_ack_e3", 1, {7'd0, dut_ack[1]}, 8'h01);
        chk("t2_dat_e3", 1, dut_dat[1], 8'h22);
        stb = 1'b0;
        step();
        chk("t2_ack_e4", 1, {7'd0, dut_ack[1]}, 8'h00);
        finish(5);

        // WS=3 aborted read, aborted write, then verifying read
        start(1'b0, 8'h20, 8'h00);
        cyc = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("t3_ack", 2, {7'd0, dut_ack[2]}, 8'h00);
            chk("t3_busy", 2, {7'd0, dut_busy[2]}, 8'h00);
        end
        chk("t3_dat_kept", 2, dut_dat[2], 8'h11);
        start(1'b1, 8'h20, 8'h99);
        cyc = 1'b0;
        repeat (4) step();
        start(1'b0, 8'h20, 8'h00);
        repeat (3) step();
        step();
        chk("t3_rd_ack", 2, {7'd0, dut_ack[2]}, 8'h01);
        chk("t3_rd_dat", 2, dut_dat[2], 8'h77);
        finish(1);

        // WS=2 clock-enable stall in WAIT and during ack
        start(1'b0, 8'h00, 8'h00);
        en = 1'b0;
        repeat (3) begin
            step();
            chk("t4_stall_ack", 3, {7'd0, dut_ack[3]}, 8'h00);
            chk("t4_stall_busy", 3, {7'd0, dut_busy[3]}, 8'h01);
        end
        en = 1'b1;
        step();
        chk("t4_ack_e4", 3, {7'd0, dut_ack[3]}, 8'h00);
        step();
        chk("t4_ack_e5", 3, {7'd0, dut_ack[3]}, 8'h00);
        step();
        chk("t4_ack_e6", 3, {7'd0, dut_ack[3]}, 8'h01);
        chk("t4_dat_e6", 3, dut_dat[3], 8'h11);
        en = 1'b0;
        step();
        chk("t4_ack_hold1", 3, {7'd0, dut_ack[3]}, 8'h01);
        step();
        chk("t4_ack_hold2", 3, {7'd0, dut_ack[3]}, 8'h01);
        en = 1'b1;
        step();
        chk("t4_ack_e9", 3, {7'd0, dut_ack[3]}, 8'h00);
        finish(2);

        // Out-of-range access on the DEPTH=128 instance
        wr(8'h90, 8'h7F);
        start(1'b0, 8'h90, 8'h00);
        step();
        step();
        chk("t5_d256_ack", 0, {7'd0, dut_ack[0]}, 8'h01);
        chk("t5_d256_dat", 0, dut_dat[0], 8'h7F);
        step();
        chk("t5_oor_ack", 3, {7'd0, dut_ack[3]}, 8'h01);
        chk("t5_oor_dat", 3, dut_dat[3], 8'h00);
        finish(2);
        start(1'b0, 8'h10, 8'h00);
        step();
        step();
        step();
        chk("t5_alias_ack", 3, {7'd0, dut_ack[3]}, 8'h01);
        chk("t5_alias_dat", 3, dut_dat[3], 8'hA5);
        finish(2);

        // Reset during the wait of a write
        start(1'b1, 8'h05, 8'h3C);
        rst_n = 1'b0;
        cyc   = 1'b0;
        step();
        chk("t6_ack", 2, {7'd0, dut_ack[2]}, 8'h00);
        chk("t6_busy", 2, {7'd0, dut_busy[2]}, 8'h00);
        chk("t6_dat", 2, dut_dat[2], 8'h00);
        chk("t6_ws0_ack", 1, {7'd0, dut_ack[1]}, 8'h00);
        rst_n = 1'b1;
        step();
        step();
        start(1'b0, 8'h05, 8'h00);
        step();
        chk("t6_ws0_dat", 1, dut_dat[1], 8'h5A);
        step();
        step();
        step();
        chk("t6_rd_ack", 2, {7'd0, dut_ack[2]}, 8'h01);
        chk("t6_rd_dat", 2, dut_dat[2], 8'h5A);
        finish(1);

        // cyc without stb is ignored
        cyc = 1'b1; stb = 1'b0;
        repeat (3) begin
            step();
            chk("idle_busy", 0, {7'd0, dut_busy[0]}, 8'h00);
        end
        cyc = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
